// File: rtl/shift_seq_ctrl.sv
// Sequential shifter: one single-bit shift per clock, covering left/right and
// logical/arithmetic/rotate modes, with a busy flag and a one-cycle done pulse.
module shift_seq_ctrl #(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [AW-1:0]    count_reg, count_next;
    logic             dir_reg, dir_next;
    logic [1:0]       mode_reg, mode_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic [WIDTH-1:0] shifted;

    // Single-step shift of the working register. In arithmetic-right mode the
    // current MSB always equals the original sign, so replicating it suffices.
    always_comb begin
        shifted = work_reg;
        if (!dir_reg) begin
            case (mode_reg)
                2'b10:   shifted = {work_reg[WIDTH-2:0], work_reg[WIDTH-1]};
                default: shifted = {work_reg[WIDTH-2:0], 1'b0};
            endcase
        end else begin
            case (mode_reg)
                2'b01:   shifted = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
                2'b10:   shifted = {work_reg[0], work_reg[WIDTH-1:1]};
                default: shifted = {1'b0, work_reg[WIDTH-1:1]};
            endcase
        end
    end

    always_comb begin
        state_next    = state_reg;
        work_next     = work_reg;
        count_next    = count_reg;
        dir_next      = dir_reg;
        mode_next     = mode_reg;
        data_out_next = data_out_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    work_next  = data_in;
                    count_next = amount;
                    dir_next   = dir;
                    mode_next  = mode;
                    if (amount == '0) begin
                        state_next    = DONE;
                        data_out_next = data_in;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Counter is never zero here: SHIFT is entered only with amount > 0.
                work_next  = shifted;
                count_next = count_reg - AW'(1);
                if (count_reg == AW'(1)) begin
                    state_next    = DONE;
                    data_out_next = shifted;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            work_reg     <= '0;
            count_reg    <= '0;
            dir_reg      <= 1'b0;
            mode_reg     <= 2'b00;
            data_out_reg <= '0;
        end else begin
            state_reg    <= state_next;
            work_reg     <= work_next;
            count_reg    <= count_next;
            dir_reg      <= dir_next;
            mode_reg     <= mode_next;
            data_out_reg <= data_out_next;
        end
    end

    assign data_out = data_out_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus pushes expected results and
// completion cycles; a negedge monitor pops and compares on every done pulse.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic [2:0] amount;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    int   dones  = 0;

    shift_seq_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .amount   (amount),
        .dir      (dir),
        .mode     (mode),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got data_out=%0h expected no done pulse (cycle %0d)",
                         data_out, cyc);
            end else begin
                e = sb.pop_front();
                check("data_out", 32'(data_out), 32'(e.data));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                $display("txn: done cycle=%0d data_out=%02h expected=%02h", cyc, data_out, e.data);
            end
        end
    end

    // Accept one operation, then scramble inputs to prove they were captured.
    task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic dr,
                         input logic [1:0] m, input logic [7:0] expv, input bit push);
        @(negedge clk);
        data_in = d;
        amount  = a;
        dir     = dr;
        mode    = m;
        start   = 1'b1;
        if (push) sb.push_back('{expv, cyc + 1 + int'(a)});
        $display("txn: start data_in=%02h amount=%0d dir=%0b mode=%02b", d, a, dr, m);
        @(negedge clk);
        start   = 1'b0;
        data_in = ~d;
        amount  = ~a;
        dir     = ~dr;
        mode    = ~m;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic finish_op(input int waits);
        repeat (waits) @(negedge clk);
        #1;
        check("op_completed", 32'(sb.size()), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic dr,
                          input logic [1:0] m, input logic [7:0] expv);
        issue(d, a, dr, m, expv, 1'b1);
        finish_op(int'(a) + 1);
    endtask

    logic [7:0] b2b_in  [12] = '{8'hA5, 8'h11, 8'h22, 8'h3C, 8'h44, 8'h55,
                                 8'h81, 8'h66, 8'h77, 8'hF0, 8'h99, 8'hBB};
    logic [7:0] b2b_exp [12] = '{8'h4A, 8'h00, 8'h00, 8'h78, 8'h00, 8'h00,
                                 8'h02, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h00};

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 8'h00;
        amount  = 3'd0;
        dir     = 1'b0;
        mode    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'hC3, 3'd2, 1'b0, 2'b00, 8'h0C);
        run_op(8'h90, 3'd3, 1'b1, 2'b01, 8'hF2);
        run_op(8'h81, 3'd1, 1'b0, 2'b10, 8'h03);
        run_op(8'h81, 3'd4, 1'b1, 2'b10, 8'h18);
        run_op(8'h5A, 3'd0, 1'b0, 2'b00, 8'h5A);

        // start pulsed mid-operation must be ignored
        issue(8'h01, 3'd7, 1'b0, 2'b00, 8'h80, 1'b1);
        repeat (2) @(negedge clk);
        start   = 1'b1;
        data_in = 8'hFF;
        amount  = 3'd0;
        @(negedge clk);
        start = 1'b0;
        finish_op(5);
        check("hold_data_out", 32'(data_out), 32'h80);

        // reset during SHIFT aborts: no done pulse, outputs cleared
        issue(8'h01, 3'd7, 1'b0, 2'b00, 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_data_out_hold", 32'(data_out), 32'd0);

        // back-to-back with start held high: accepted every third cycle
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            start   = 1'b1;
            data_in = b2b_in[j];
            amount  = 3'd1;
            dir     = 1'b0;
            mode    = 2'b00;
            if (j % 3 == 0) sb.push_back('{b2b_exp[j], cyc + 2});
        end
        @(negedge clk);
        start = 1'b0;
        finish_op(3);

        check("total_dones", 32'(dones), 32'd10);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 8, data width in bits (WIDTH >= 2, power of two).
REQ-002 The module SHALL define AW = clog2(WIDTH) as a derived local value, not an override.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request a new shift operation; sampled in IDLE only.
REQ-006 data_in  input  WIDTH  operand, captured when start is accepted.
REQ-007 amount  input  AW  number of single-bit shift steps (0..WIDTH-1), captured with data_in.
REQ-008 dir  input  1  0 = left, 1 = right; captured with data_in.
REQ-009 mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical; captured with data_in.
REQ-010 data_out  output  WIDTH  result of the last completed operation.
REQ-011 busy  output  1  high while an operation is in flight (states SHIFT and DONE).
REQ-012 done  output  1  single-cycle completion pulse.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 SHALL, at that edge (E0), load the working register from data_in, load the step counter from amount, and latch dir and mode.
- If amount=0, the FSM SHALL go to DONE.
- Otherwise the FSM SHALL go to SHIFT.
REQ-015 SHIFT SHALL perform exactly one single-bit shift of the working register per cycle and decrement the counter.
- The FSM SHALL go to DONE on the edge that performs the last step.
REQ-016 Latency: for amount N, the shifts SHALL occur on edges E0+1..E0+N, and done SHALL be high for exactly the one cycle following edge E0+N (N=0 included).
REQ-017 data_out SHALL be updated with the final working-register value on the edge entering DONE and SHALL hold it until the next completion.
REQ-018 DONE SHALL last one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-019 Left shift: logical and arithmetic modes SHALL insert 0 at the LSB; rotate SHALL move the MSB into the LSB.
REQ-020 Right shift:
- Logical mode SHALL insert 0 at the MSB.
- Arithmetic mode SHALL replicate the original MSB (sign).
- Rotate mode SHALL move the LSB into the MSB.
REQ-021 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-022 Changes on data_in, amount, dir and mode after acceptance SHALL NOT affect the in-flight operation.
REQ-023 If start is held high continuously, a new operation SHALL be accepted on the first IDLE edge after DONE, i.e. one idle cycle between the done pulse and the next acceptance.
REQ-024 busy SHALL be low in IDLE; it SHALL rise the cycle after acceptance and fall the cycle after DONE.
REQ-025 No arithmetic overflow SHALL exist; the counter width is AW and never wraps below 0.

Reset
REQ-026 With rst_n=0 at a rising edge, the FSM SHALL go to IDLE and the following SHALL clear to 0 on that edge, regardless of state: data_out, busy, done, the working register, the counter and the latched dir/mode.
REQ-027 Reset during SHIFT or DONE SHALL abort the operation: no done pulse and data_out = 0.
REQ-028 Reset SHALL take priority over start; start is honoured only on an edge with rst_n=1.

Verification (WIDTH=8)
REQ-029 Left logical: data_in=8'hC3, amount=2, dir=0, mode=00, start pulse -> done in the cycle after the 2nd post-start edge; data_out=8'h0C.
REQ-030 Right arithmetic: data_in=8'h90, amount=3, dir=1, mode=01 -> done after 3 steps; data_out=8'hF2.
REQ-031 Rotate:
- data_in=8'h81, amount=1, dir=0, mode=10 -> data_out=8'h03.
- Then data_in=8'h81, amount=4, dir=1, mode=10 -> data_out=8'h18.
REQ-032 Zero amount: data_in=8'h5A, amount=0 -> done the cycle after acceptance, busy high for that one cycle only; data_out=8'h5A.
REQ-033 Ignored start / reset abort:
- Accept data_in=8'h01, amount=7, dir=0, mode=00.
- Pulse start with data_in=8'hFF at step 2 -> ignored; final data_out=8'h80.
- Repeat the operation and assert rst_n=0 at step 4 -> busy=0, done never pulses, data_out=8'h00.
REQ-034 Back-to-back: start held high, amount=1 -> done pulses every 3rd cycle; each result matches a single 1-bit shift of the data_in value sampled at its acceptance.
